// File: rtl/switch_out_arbiter.sv
// Output-port grant arbiter: wormhole-locked one-hot grant with tail/idle-timeout release.
// Define SWITCH_ARB_ROUND_ROBIN_EN for rotating priority; default build is fixed priority.
module switch_out_arbiter #(
   parameter int PORTS        = 5,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] requests,
   input  logic [PORTS-1:0] tails,
   input  logic             out_req,
   input  logic             out_ack,
   output logic [PORTS-1:0] grants,
   output logic             busy
);

   localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state, state_next;
   logic [PORTS-1:0] grants_next;
   logic [PORTS-1:0] winner;
   logic [CNT_W-1:0] stall_cnt, stall_next;
   logic             transfer, tail_xfer, owner_req, timeout;

`ifdef SWITCH_ARB_ROUND_ROBIN_EN
   localparam int IDX_W = $clog2(PORTS);
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] win_idx;

   // Descending scan so the requester closest after ptr is written last and wins.
   always_comb begin
      winner  = '0;
      win_idx = '0;
      for (int k = PORTS; k >= 1; k--) begin
         if (requests[(int'(ptr) + k) % PORTS]) begin
            winner = '0;
            winner[(int'(ptr) + k) % PORTS] = 1'b1;
            win_idx = IDX_W'((int'(ptr) + k) % PORTS);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= IDX_W'(PORTS - 1);
      end else if (state == IDLE && |requests) begin
         ptr <= win_idx;
      end
   end
`else
   always_comb begin
      winner = '0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         if (requests[i]) begin
            winner    = '0;
            winner[i] = 1'b1;
         end
      end
   end
`endif

   assign transfer  = out_req & out_ack;
   assign tail_xfer = transfer & |(tails & grants);
   assign owner_req = |(requests & grants);
   assign busy      = |grants;

   always_comb begin
      stall_next = '0;
      if (state == GRANT && !transfer) begin
         stall_next = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + CNT_W'(1);
      end
   end

   // A deserted grant is dropped only once its owner has stopped requesting.
   assign timeout = (IDLE_TIMEOUT != 0) && (state == GRANT) && !owner_req &&
                    (stall_next == CNT_MAX);

   always_comb begin
      state_next  = state;
      grants_next = grants;
      case (state)
         IDLE: begin
            if (|requests) begin
               grants_next = winner;
               state_next  = GRANT;
            end
         end
         GRANT: begin
            if (tail_xfer || timeout) begin
               grants_next = '0;
               state_next  = IDLE;
            end
         end
         default: begin
            grants_next = '0;
            state_next  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grants    <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_next;
         grants    <= grants_next;
         stall_cnt <= stall_next;
      end
   end

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Scoreboard bench for switch_out_arbiter: a cycle model pushes expected grants, sampled after each edge.
module tb_switch_out_arbiter;

   logic       clk;
   logic       rst;
   logic [4:0] requests;
   logic [4:0] tails;
   logic       out_req;
   logic       out_ack;
   logic [4:0] grants;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [4:0] exp_q[$];

   int m_g     = -1;
   int m_stall = 0;
   int m_ptr   = 4;

   switch_out_arbiter #(.PORTS(5), .IDLE_TIMEOUT(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .requests (requests),
      .tails    (tails),
      .out_req  (out_req),
      .out_ack  (out_ack),
      .grants   (grants),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_g     = -1;
      m_stall = 0;
      m_ptr   = 4;
   endtask

   // Reference behaviour for one clock edge given the inputs currently driven.
   task automatic model_edge(output logic [4:0] e);
      int w;
      if (m_g < 0) begin
         if (requests != 5'b0) begin
            w = -1;
`ifdef SWITCH_ARB_ROUND_ROBIN_EN
            for (int k = 1; k <= 5; k++)
               if (w < 0 && requests[(m_ptr + k) % 5]) w = (m_ptr + k) % 5;
            m_ptr = w;
`else
            for (int i = 0; i < 5; i++)
               if (w < 0 && requests[i]) w = i;
`endif
            m_g     = w;
            m_stall = 0;
         end
      end else begin
         if (out_req && out_ack) begin
            if (tails[m_g]) m_g = -1;
            m_stall = 0;
         end else begin
            if (m_stall < 16) m_stall++;
            if (m_stall == 16 && !requests[m_g]) begin
               m_g     = -1;
               m_stall = 0;
            end
         end
      end
      e = (m_g < 0) ? 5'b0 : 5'(1 << m_g);
   endtask

   task automatic step();
      logic [4:0] e;
      model_edge(e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("grants", grants, e);
         check("busy", busy, |e);
      end
   endtask

   task automatic release_tail();
      out_req = 1'b1;
      out_ack = 1'b1;
      tails   = 5'b11111;
      step();
      out_req  = 1'b0;
      out_ack  = 1'b0;
      tails    = 5'b0;
      requests = 5'b0;
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_grants", grants, 5'b0);
      check("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int order[6];
      rst = 1'b1; requests = 5'b0; tails = 5'b0; out_req = 1'b0; out_ack = 1'b0;
      model_reset();
      #1;
      check("reset_grants", grants, 5'b0);
      check("reset_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First arbitration after reset
      requests = 5'b10110;
      step();
      check("first_grant", grants, 5'b00010);
      check("first_busy", busy, 1'b1);
      out_req = 1'b1; out_ack = 1'b1; tails = 5'b00010;
      step();
      check("first_release", grants, 5'b0);
      out_req = 1'b0; out_ack = 1'b0; tails = 5'b0;
      step();
`ifdef SWITCH_ARB_ROUND_ROBIN_EN
      check("second_grant", grants, 5'b00100);
`else
      check("second_grant", grants, 5'b00010);
`endif
      release_tail();

      // 3-flit packet from port 3
      requests = 5'b01000;
      step();
      check("pkt3_grant", grants, 5'b01000);
      out_req = 1'b1; out_ack = 1'b1; tails = 5'b0;
      step();
      step();
      check("pkt3_body", grants, 5'b01000);
      tails = 5'b01000;
      step();
      check("pkt3_tail_release", grants, 5'b0);
      out_req = 1'b0; out_ack = 1'b0; tails = 5'b0;
      step();
      check("pkt3_regrant", grants, 5'b01000);
      release_tail();

      // Backpressure with owner still requesting never times out
      requests = 5'b00001;
      step();
      out_req = 1'b1; out_ack = 1'b0;
      for (int i = 0; i < 40; i++) step();
      check("hold40", grants, 5'b00001);
      out_req = 1'b0;
      release_tail();

      // Deserted grant released after 16 stall cycles
      requests = 5'b00100;
      step();
      requests = 5'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 15) check("timeout_held15", grants, 5'b00100);
         if (i == 16) check("timeout_release16", grants, 5'b0);
      end

      // Asynchronous reset mid-packet
      requests = 5'b10000;
      step();
      check("south_grant", grants, 5'b10000);
      out_req = 1'b1;
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_grants", grants, 5'b0);
      check("async_rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_req = 1'b0;
      step();
      check("post_rst_grant", grants, 5'b10000);
      release_tail();

      // All five contend with single-flit packets
      do_reset();
`ifdef SWITCH_ARB_ROUND_ROBIN_EN
      order = '{0, 1, 2, 3, 4, 0};
`else
      order = '{0, 0, 0, 0, 0, 0};
`endif
      requests = 5'b11111; tails = 5'b11111;
      for (int n = 0; n < 6; n++) begin
         out_req = 1'b0; out_ack = 1'b0;
         step();
         check("rr_order", grants, 5'(1 << order[n]));
         out_req = 1'b1; out_ack = 1'b1;
         step();
         check("rr_bubble", grants, 5'b0);
      end
      release_tail();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_out_arbiter.md
Name: switch_out_arbiter

Overview:
- Per-output-port arbiter that produces the one-hot `grants` vector for the output-port switch multiplexer.
- One instance sits beside each of the router's five output multiplexers.
- Watches requests from the five input buffers (local, west, north, east, south) and the output req/ack handshake.
- Holds a grant for a whole packet (wormhole lock) and releases it on the tail-flit transfer or on a stall timeout.

Parameters:
- PORTS, 5: number of requesters; fixed at 5 to match the multiplexer, other values unsupported.
- IDLE_TIMEOUT, 16: consecutive no-transfer cycles after which a deserted grant is released; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- requests  input  5  bit i = input buffer i holds a flit routed to this output port
- tails  input  5  bit i = the flit currently presented by buffer i is a tail (or single-flit packet)
- out_req  input  1  req of the output port, as driven through the multiplexer
- out_ack  input  1  ack returned by the downstream port
- grants  output  5  one-hot grant to the multiplexer; all-zero = port free
- busy  output  1  high while any grant is held (OR of grants)

Behaviour:
- Reset:
  - rst asserted: grants=0, busy=0, state=IDLE, stall counter=0, round-robin pointer=4; takes effect immediately, no clock needed.
  - Reset mid-packet drops the grant at once; no flit is completed.
- State IDLE (grants=0):
  - If requests!=0, the winner is chosen combinationally; grants is registered, one-hot on the next edge; go to GRANT.
  - Latency: request to grant = 1 cycle.
- State GRANT (grants=one-hot g):
  - A transfer is a cycle where out_req & out_ack = 1.
  - Transfer with tails[g]=1: grants=0 on the next edge; return to IDLE.
  - Exactly one idle bubble cycle follows each release; re-arbitration happens in that IDLE cycle.
  - Transfer with tails[g]=0: hold the grant; stall counter=0.
  - No transfer: stall counter +1, saturating at IDLE_TIMEOUT.
  - Counter == IDLE_TIMEOUT and requests[g]=0 (IDLE_TIMEOUT!=0): release to IDLE and raise the timeout flag.
  - If requests[g] is still 1, the grant is held indefinitely: downstream backpressure never breaks a packet.
  - requests[g] dropping mid-packet does not release the grant; only a tail transfer or the timeout releases it.
- Arbitration (macro absent): fixed priority local(0) > west(1) > north(2) > east(3) > south(4).
- Invariants:
  - grants is never multi-hot.
  - grants never changes while in GRANT except on release.
  - busy = |grants, driven combinationally from the register.
- Widths: stall counter is $clog2(IDLE_TIMEOUT+1) bits, min 1.

Optional Feature:
- Macro: SWITCH_ARB_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority; search starts at (pointer+1) mod 5 and wraps 4 to 0.
  - On each grant, pointer <= winner index.
  - Reset pointer=4, so the first arbitration after reset matches fixed priority.
- Undefined: pointer logic absent; fixed priority as in Behaviour.
- Grant/release timing is identical in both builds.

Test Plan:
- Reset, then requests=5'b10110 → grants=5'b00010 one cycle later, busy=1. With RR defined, the next arbitration (still 5'b10110) → 5'b00100.
- 3-flit packet from port 3: two transfers with tails=0, then a transfer with tails[3]=1 → grants=5'b01000 through the tail cycle, 0 the next cycle, regranted after one bubble.
- Granted port 0 with out_ack held 0 for 40 cycles while requests[0]=1 → grant held throughout, no timeout.
- Granted port 2; requests[2] drops, no transfers, IDLE_TIMEOUT=16 → grants=0 exactly 16 stall cycles later. With IDLE_TIMEOUT=0 the grant holds forever.
- All five requesting continuously, single-flit packets, RR defined → grant order 0,1,2,3,4,0 with one bubble between grants. Fixed-priority build → port 0 every time.
- Assert rst mid-packet (grants=5'b10000) between clock edges → grants=0 and busy=0 immediately. After release, requests=5'b10000 → grant 5'b10000 one cycle later.
